// File: rtl/mac_pkg.sv
// Shared types and constants for the sequential multiply-accumulate controller.
package mac_pkg;

  localparam int MUL_STEPS = 8;
  localparam int BYTE_W    = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_ACC,
    S_DONE
  } mac_state_t;

endpackage

// File: rtl/cla_8bit.sv
// 8-bit carry-lookahead adder: every carry is a flat sum of generate terms
// gated by the propagate terms above them.
module cla_8bit (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);

  logic [7:0] gen;
  logic [7:0] prop;
  logic [8:0] carry;
  logic       term;

  assign gen  = a_i & b_i;
  assign prop = a_i ^ b_i;

  always_comb begin
    carry = '0;
    term  = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      term = cin_i;
      for (int j = 0; j < i; j++) term = term & prop[j];
      carry[i] = term;
      for (int j = 0; j < i; j++) begin
        term = gen[j];
        for (int m = j + 1; m < i; m++) term = term & prop[m];
        carry[i] = carry[i] | term;
      end
    end
  end

  assign sum_o  = prop ^ carry[7:0];
  assign cout_o = carry[8];

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequential 8x8 unsigned multiply-accumulate controller sharing one cla_8bit
// between shift-add multiplication and byte-serial accumulation.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [7:0]       a_i,
  input  logic [7:0]       b_i,
  input  logic             clr_acc_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [15:0]      product_o,
  output logic [ACC_W-1:0] acc_o,
  output logic             ovf_o
);

  localparam int NB = ACC_W / BYTE_W;
  localparam int KW = $clog2(NB);
  localparam logic [KW-1:0] LAST_K    = KW'(NB - 1);
  localparam logic [2:0]    LAST_STEP = 3'(MUL_STEPS - 1);

  typedef logic [NB-1:0][BYTE_W-1:0] acc_bytes_t;

  mac_state_t  state_q, state_d;
  logic [7:0]  mcand_q, mcand_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  logic        clr_q, clr_d;
  logic [2:0]  step_q, step_d;
  logic [KW-1:0] byte_q, byte_d;
  logic        carry_q, carry_d;
  acc_bytes_t  shadow_q, shadow_d;
  acc_bytes_t  acc_q, acc_d;
  logic        ovf_q, ovf_d;
  logic [15:0] product_q, product_d;

  acc_bytes_t  shadowNext;
  logic [7:0]  addA, addB, addSum;
  logic        addCin, addCout;

  cla_8bit u_cla (
    .a_i    (addA),
    .b_i    (addB),
    .cin_i  (addCin),
    .sum_o  (addSum),
    .cout_o (addCout)
  );

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    clr_d      = clr_q;
    step_d     = step_q;
    byte_d     = byte_q;
    carry_d    = carry_q;
    shadow_d   = shadow_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    product_d  = product_q;
    shadowNext = shadow_q;
    addA       = '0;
    addB       = '0;
    addCin     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mcand_d = a_i;
          lo_d    = b_i;
          clr_d   = clr_acc_i;
          hi_d    = '0;
          step_d  = '0;
          state_d = S_MUL;
        end
      end
      // Classic shift-add: the carry-out becomes the new top bit of H.
      S_MUL: begin
        addA   = hi_q;
        addB   = lo_q[0] ? mcand_q : '0;
        hi_d   = {addCout, addSum[7:1]};
        lo_d   = {addSum[0], lo_q[7:1]};
        step_d = step_q + 3'd1;
        if (step_q == LAST_STEP) begin
          byte_d  = '0;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        addA   = clr_q ? '0 : acc_q[byte_q];
        addB   = (byte_q == KW'(0)) ? lo_q : ((byte_q == KW'(1)) ? hi_q : '0);
        addCin = (byte_q == KW'(0)) ? 1'b0 : carry_q;
        shadowNext[byte_q] = addSum;
        shadow_d = shadowNext;
        carry_d  = addCout;
        byte_d   = byte_q + KW'(1);
        if (byte_q == LAST_K) begin
          acc_d     = shadowNext;
          ovf_d     = (clr_q ? 1'b0 : ovf_q) | addCout;
          product_d = {hi_q, lo_q};
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      clr_q     <= 1'b0;
      step_q    <= '0;
      byte_q    <= '0;
      carry_q   <= 1'b0;
      shadow_q  <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      clr_q     <= clr_d;
      step_q    <= step_d;
      byte_q    <= byte_d;
      carry_q   <= carry_d;
      shadow_q  <= shadow_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      product_q <= product_d;
    end
  end

  assign ready_o   = (state_q == S_IDLE);
  assign done_o    = (state_q == S_DONE);
  assign product_o = product_q;
  assign acc_o     = acc_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed self-checking bench for mac_seq_ctrl with hand-computed results.
module tb_mac_seq_ctrl;

  localparam int ACC_W   = 24;
  localparam int NB      = ACC_W / 8;
  // Posedges from the accepting edge until done is first seen high.
  localparam int LATENCY = 8 + NB;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [7:0]       a;
  logic [7:0]       b;
  logic             clrAcc;
  logic             ready;
  logic             done;
  logic [15:0]      product;
  logic [ACC_W-1:0] acc;
  logic             ovf;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  mac_seq_ctrl #(.ACC_W(ACC_W)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .a_i       (a),
    .b_i       (b),
    .clr_acc_i (clrAcc),
    .ready_o   (ready),
    .done_o    (done),
    .product_o (product),
    .acc_o     (acc),
    .ovf_o     (ovf)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One full operation: accept, scramble inputs, wait for done, confirm single pulse.
  task automatic applyStimulus(input logic [7:0] opA, input logic [7:0] opB,
                               input logic opClr, input string tag);
    int waitCnt;
    waitCnt = 0;
    while (!ready && waitCnt < 40) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    checkOutput({tag, " ready before start"}, 32'(ready), 32'd1);
    start  = 1'b1;
    a      = opA;
    b      = opB;
    clrAcc = opClr;
    @(posedge clk); #1;
    start  = 1'b0;
    a      = ~opA;
    b      = ~opB;
    clrAcc = ~opClr;
    waitCnt = 0;
    while (!done && waitCnt < 40) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    checkOutput({tag, " latency"}, 32'(waitCnt), 32'(LATENCY));
    @(posedge clk); #1;
    checkOutput({tag, " done one cycle"}, 32'(done), 32'd0);
    checkOutput({tag, " ready after done"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int acceptIdx[$];
    int doneCnt;
    logic doneSeen;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; clrAcc = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset ready",   32'(ready),   32'd1);
    checkOutput("reset done",    32'(done),    32'd0);
    checkOutput("reset product", 32'(product), 32'd0);
    checkOutput("reset acc",     32'(acc),     32'd0);
    checkOutput("reset ovf",     32'(ovf),     32'd0);

    applyStimulus(8'h0F, 8'h0A, 1'b1, "0Fx0A");
    checkOutput("0Fx0A product", 32'(product), 32'h0096);
    checkOutput("0Fx0A acc",     32'(acc),     32'h000096);
    checkOutput("0Fx0A ovf",     32'(ovf),     32'd0);

    applyStimulus(8'hFF, 8'hFF, 1'b1, "FFxFF clr");
    checkOutput("FFxFF clr product", 32'(product), 32'hFE01);
    checkOutput("FFxFF clr acc",     32'(acc),     32'h00FE01);
    applyStimulus(8'hFF, 8'hFF, 1'b0, "FFxFF acc");
    checkOutput("FFxFF acc product", 32'(product), 32'hFE01);
    checkOutput("FFxFF acc acc",     32'(acc),     32'h01FC02);

    // 258 * 0xFE01 = 16776450 = 0xFFFD02; one more wraps to 0x00FB03 with carry-out.
    applyStimulus(8'hFF, 8'hFF, 1'b1, "ovf op1");
    for (int i = 2; i <= 258; i++) applyStimulus(8'hFF, 8'hFF, 1'b0, "ovf run");
    checkOutput("op258 acc", 32'(acc), 32'hFFFD02);
    checkOutput("op258 ovf", 32'(ovf), 32'd0);
    applyStimulus(8'hFF, 8'hFF, 1'b0, "op259");
    checkOutput("op259 acc", 32'(acc), 32'h00FB03);
    checkOutput("op259 ovf", 32'(ovf), 32'd1);
    applyStimulus(8'h01, 8'h01, 1'b1, "1x1 clr");
    checkOutput("1x1 clr product", 32'(product), 32'h0001);
    checkOutput("1x1 clr acc",     32'(acc),     32'h000001);
    checkOutput("1x1 clr ovf",     32'(ovf),     32'd0);

    // start held: accepts on negedge indices 0, 13, 26 of the 30-cycle window.
    start = 1'b1; a = 8'h01; b = 8'h01; clrAcc = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 30) start = 1'b0;
      if (start && ready) acceptIdx.push_back(i);
      if (done) doneCnt++;
    end
    checkOutput("held accepts", 32'(acceptIdx.size()), 32'd3);
    if (acceptIdx.size() >= 2)
      checkOutput("held spacing", 32'(acceptIdx[1] - acceptIdx[0]), 32'd13);
    checkOutput("held dones", 32'(doneCnt), 32'd3);
    checkOutput("held acc",   32'(acc),     32'h000004);

    @(posedge clk); #1;
    start = 1'b1; a = 8'hFF; b = 8'hFF; clrAcc = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("rst op accepted", 32'(ready), 32'd0);
    doneSeen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      doneSeen = doneSeen | done;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst ready",   32'(ready),   32'd1);
    checkOutput("rst acc",     32'(acc),     32'd0);
    checkOutput("rst product", 32'(product), 32'd0);
    checkOutput("rst ovf",     32'(ovf),     32'd0);
    repeat (15) begin
      @(posedge clk); #1;
      doneSeen = doneSeen | done;
    end
    checkOutput("rst no done", 32'(doneSeen), 32'd0);

    applyStimulus(8'h03, 8'h05, 1'b0, "3x5");
    checkOutput("3x5 product", 32'(product), 32'h000F);
    checkOutput("3x5 acc",     32'(acc),     32'h00000F);
    applyStimulus(8'h01, 8'h01, 1'b0, "1x1 acc");
    checkOutput("1x1 acc acc", 32'(acc), 32'h000010);
    applyStimulus(8'h00, 8'hC3, 1'b0, "00xC3");
    checkOutput("00xC3 product", 32'(product), 32'h0000);
    checkOutput("00xC3 acc",     32'(acc),     32'h000010);
    checkOutput("00xC3 ovf",     32'(ovf),     32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
